// File: rtl/md_pkg.sv
// Shared op codes, state encoding and result payload for the HI/LO multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_CNT_W  = 4;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MFHI  = 3'b100;
    localparam logic [2:0] MD_MFLO  = 3'b101;
    localparam logic [2:0] MD_MTHI  = 3'b110;
    localparam logic [2:0] MD_MTLO  = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    typedef struct packed {
        logic [MD_DATA_W-1:0] hi;
        logic [MD_DATA_W-1:0] lo;
    } md_res_t;

    // Ops that open a busy window (mult/multu/div/divu).
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 signed/unsigned multiply and divide producing {hi, lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]           op,
    input  logic [MD_DATA_W-1:0] a,
    input  logic [MD_DATA_W-1:0] b,
    output md_res_t              res_c,
    output logic                 div_zero_c
);

    logic signed [63:0]          a_s64;
    logic signed [63:0]          b_s64;
    logic signed [63:0]          prod_s;
    logic        [63:0]          prod_u;
    logic                        b_zero;
    logic                        ovf;
    logic        [MD_DATA_W-1:0] sdivisor;
    logic        [MD_DATA_W-1:0] udivisor;
    logic signed [MD_DATA_W-1:0] q_s;
    logic signed [MD_DATA_W-1:0] r_s;
    logic        [MD_DATA_W-1:0] q_u;
    logic        [MD_DATA_W-1:0] r_u;

    // Divisors are forced to 1 for /0 and the signed overflow case so the
    // datapath never evaluates an undefined quotient.
    always_comb begin
        a_s64    = {{32{a[31]}}, a};
        b_s64    = {{32{b[31]}}, b};
        prod_s   = a_s64 * b_s64;
        prod_u   = {32'd0, a} * {32'd0, b};
        b_zero   = (b == 32'd0);
        ovf      = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sdivisor = (b_zero || ovf) ? 32'd1 : b;
        udivisor = b_zero ? 32'd1 : b;
        q_s      = $signed(a) / $signed(sdivisor);
        r_s      = $signed(a) % $signed(sdivisor);
        q_u      = a / udivisor;
        r_u      = a % udivisor;
    end

    always_comb begin
        res_c      = '0;
        div_zero_c = 1'b0;
        case (op)
            MD_MULT:  res_c = md_res_t'(prod_s);
            MD_MULTU: res_c = md_res_t'(prod_u);
            MD_DIV: begin
                div_zero_c = b_zero;
                if (ovf) begin
                    res_c.hi = 32'd0;
                    res_c.lo = 32'h8000_0000;
                end else begin
                    res_c.hi = r_s;
                    res_c.lo = q_s;
                end
            end
            MD_DIVU: begin
                div_zero_c = b_zero;
                res_c.hi   = r_u;
                res_c.lo   = q_u;
            end
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, shadowed commit,
// mfhi/mflo read path and D-stage stall generation.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           ALU_MD_ctrl,
    input  logic [MD_DATA_W-1:0] A,
    input  logic [MD_DATA_W-1:0] B,
    input  logic                 D_md_use,
    output logic                 busy,
    output logic                 md_stall,
    output logic [MD_DATA_W-1:0] HI,
    output logic [MD_DATA_W-1:0] LO,
    output logic [MD_DATA_W-1:0] md_out
);

    logic [1:0]           state,     state_nxt;
    logic [MD_CNT_W-1:0]  cnt,       cnt_nxt;
    md_res_t              shadow,    shadow_nxt;
    logic                 shadow_dz, shadow_dz_nxt;
    logic                 busy_nxt;
    logic [MD_DATA_W-1:0] hi_nxt,    lo_nxt;

    md_res_t              arith_res;
    logic                 arith_dz;

    md_arith u_arith (
        .op         (ALU_MD_ctrl),
        .a          (A),
        .b          (B),
        .res_c      (arith_res),
        .div_zero_c (arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            shadow_dz <= 1'b0;
            busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            shadow_dz <= shadow_dz_nxt;
            busy      <= busy_nxt;
            HI        <= hi_nxt;
            LO        <= lo_nxt;
        end
    end

    // Result is captured at launch; the busy window only models latency.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shadow_nxt    = shadow;
        shadow_dz_nxt = shadow_dz;
        busy_nxt      = busy;
        hi_nxt        = HI;
        lo_nxt        = LO;
        case (state)
            IDLE: begin
                if (start) begin
                    case (ALU_MD_ctrl)
                        MD_MULT, MD_MULTU: begin
                            state_nxt     = MUL;
                            cnt_nxt       = MD_CNT_W'(MULT_CYCLES);
                            shadow_nxt    = arith_res;
                            shadow_dz_nxt = 1'b0;
                            busy_nxt      = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_nxt     = DIV;
                            cnt_nxt       = MD_CNT_W'(DIV_CYCLES);
                            shadow_nxt    = arith_res;
                            shadow_dz_nxt = arith_dz;
                            busy_nxt      = 1'b1;
                        end
                        MD_MTHI: hi_nxt = A;
                        MD_MTLO: lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == MD_CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    if (!shadow_dz) begin
                        hi_nxt = shadow.hi;
                        lo_nxt = shadow.lo;
                    end
                end else begin
                    cnt_nxt = cnt - MD_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Stall also covers the launch cycle itself, before busy has risen.
    assign md_stall = D_md_use & (busy | (start & is_arith(ALU_MD_ctrl)));
    assign md_out   = (ALU_MD_ctrl == MD_MFHI) ? HI : LO;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected commits are queued at launch and
// checked by a monitor when busy falls; other checks are directed.
module tb_md_sched;
    import md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALU_MD_ctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   bcnt   = 0;
    logic prev_busy = 1'b0;

    md_sched dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALU_MD_ctrl (ALU_MD_ctrl),
        .A           (A),
        .B           (B),
        .D_md_use    (D_md_use),
        .busy        (busy),
        .md_stall    (md_stall),
        .HI          (HI),
        .LO          (LO),
        .md_out      (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_commit(input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; drives for one cycle and returns on the next negedge.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start       = 1'b1;
        ALU_MD_ctrl = op;
        A           = a;
        B           = b;
        @(negedge clk);
        start       = 1'b0;
        ALU_MD_ctrl = MD_MFLO;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s busy_timeout actual=%b required=0", name, busy);
        end
    endtask

    // Commit monitor: measures the busy window and checks HI/LO when it closes.
    always @(negedge clk) begin
        if (!reset) begin
            bcnt      = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit actual=HI:%h LO:%h required=none", HI, LO);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("busy_len", 32'(bcnt), 32'(mon_e.len));
                    chk("commit_hi", HI, mon_e.hi);
                    chk("commit_lo", LO, mon_e.lo);
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    always @(posedge clk) begin
        if (reset && start && busy) $error("illegal start while busy");
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns;
        reset       = 1'b0;
        start       = 1'b0;
        D_md_use    = 1'b0;
        ALU_MD_ctrl = MD_MFLO;
        A           = '0;
        B           = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        launch(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        chk("mult_busy_t1", 32'(busy), 32'd1);
        wait_idle("mult");

        expect_commit(32'h0000_0001, 32'hFFFF_FFFE, 5);
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu");

        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div");

        expect_commit(32'd1, 32'd3, 10);
        launch(MD_DIVU, 32'd7, 32'd2);
        wait_idle("divu");

        launch(MD_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo", LO, 32'd3);

        expect_commit(32'h1234_5678, 32'd3, 10);
        launch(MD_DIV, 32'd5, 32'd0);
        wait_idle("div_zero");
        start       = 1'b1;
        ALU_MD_ctrl = MD_MFLO;
        #1 chk("mflo_out", md_out, 32'd3);
        @(negedge clk);
        start       = 1'b0;
        ALU_MD_ctrl = MD_MFHI;
        #1 chk("mfhi_out", md_out, 32'h1234_5678);
        @(negedge clk);

        expect_commit(32'd0, 32'h8000_0000, 10);
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        launch(MD_MTLO, 32'hCAFE_BABE, 32'd0);
        chk("mtlo_lo", LO, 32'hCAFE_BABE);
        chk("mtlo_hi", HI, 32'd0);

        // Stall spans the launch cycle plus every busy cycle.
        expect_commit(32'd0, 32'd12, 5);
        D_md_use    = 1'b1;
        start       = 1'b1;
        ALU_MD_ctrl = MD_MULT;
        A           = 32'd3;
        B           = 32'd4;
        ns          = 0;
        for (int i = 0; i < 10; i++) begin
            #1 if (md_stall) ns++;
            @(negedge clk);
            start       = 1'b0;
            ALU_MD_ctrl = MD_MFLO;
        end
        chk("stall_cycles", 32'(ns), 32'd6);
        wait_idle("stall_mult");
        #1 chk("mflo_no_stall", 32'(md_stall), 32'd0);
        start       = 1'b1;
        ALU_MD_ctrl = MD_MFHI;
        #1 chk("mfhi_start_no_stall", 32'(md_stall), 32'd0);
        chk("mfhi_out_zero", md_out, 32'd0);
        @(negedge clk);
        start    = 1'b0;
        D_md_use = 1'b0;

        expect_commit(32'd0, 32'd21, 5);
        launch(MD_MULTU, 32'd3, 32'd7);
        wait_idle("b2b_first");
        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        launch(MD_MULT, 32'hFFFF_FFFD, 32'd2);
        wait_idle("b2b_second");

        // Reset mid-divide: no commit may follow.
        launch(MD_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_hi", HI, 32'd0);
        chk("post_abort_lo", LO, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencer for the pipeline's shared multiply/divide resource (HI/LO unit), driven by the 3-bit ALU_MD_ctrl op code that the EX-stage control already produces.
- Accepts one mult/multu/div/divu/mthi/mtlo launch per start pulse from E, holds a fixed-latency busy window and commits HI/LO at the end of it.
- Serves mfhi/mflo reads and raises a stall toward D whenever a HI/LO-using instruction in D must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is an MD launch this cycle. Single-cycle qualifier, sampled at the rising edge.
- ALU_MD_ctrl  in  3  op code:
  - 000 mult, 001 multu, 010 div, 011 divu
  - 100 mfhi, 101 mflo
  - 110 mthi, 111 mtlo
- A  in  32  rs operand (E stage).
- B  in  32  rt operand (E stage).
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  unit executing a mult/div.
- md_stall  out  1  stall request to D/F.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- md_out  out  32  HI when ALU_MD_ctrl==100, else LO. Combinational; goes to the AO_M mux.

Behaviour:
- Reset (async, reset==0):
  - State IDLE, counter=0, busy=0.
  - HI=0, LO=0.
  - Shadow result registers cleared.
  - Any in-flight operation is discarded with no commit.
- FSM states: IDLE, MUL, DIV.
- Launch from IDLE (start=1 sampled at edge T0):
  - 000/001: go to MUL, load counter with MULT_CYCLES.
  - 010/011: go to DIV, load counter with DIV_CYCLES.
  - In both cases, capture the full result into shadow registers at T0:
    - Multiply: 64-bit product, HI = upper 32 bits, LO = lower 32 bits. Signed for 000, unsigned for 001.
    - Divide: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. Signed for 010, unsigned for 011.
- Busy window:
  - busy=1 for exactly N cycles, from T0+1 through T0+N (N = the cycle count for the op).
  - The counter decrements every cycle while in MUL or DIV.
  - When the counter reaches 1, the next edge commits shadow to HI/LO, returns to IDLE and drops busy.
  - New HI/LO values are visible in cycle T0+N+1.
- mthi/mtlo (110/111) with start=1 in IDLE:
  - HI<=A or LO<=A at the edge.
  - No busy window; stays in IDLE.
- mfhi/mflo with start=1: no state change. md_out reflects the current HI/LO.
- Divide by zero (B==0, op 010/011):
  - Full DIV_CYCLES busy window still runs.
  - At commit, HI and LO are left unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start=1 while busy=1:
  - Illegal, because md_stall must prevent it.
  - Ignored: no state or register change.
  - The bench flags it as an assertion failure.
- md_stall = D_md_use & (busy | (start & ALU_MD_ctrl in {000,001,010,011})).
  - This covers the launch cycle itself, before busy rises.
- Back-to-back operations: a new start is legal in cycle T0+N+1, the first cycle with busy=0.
- Simultaneous reset deassertion and start: the start is sampled at the first edge after deassertion only.

Decomposition:
- Package md_pkg holds:
  - the op-code constants MD_MULT..MD_MTLO (3'b000..3'b111),
  - the state encoding IDLE/MUL/DIV,
  - the default latencies.
- One sub-module, md_arith: combinational signed/unsigned 32x32 multiply and divide producing {hi,lo}, plus a div-by-zero flag.
- md_sched owns the FSM, counter, shadow registers, HI/LO and stall logic.

Test Plan:
- mult A=0xFFFFFFFF B=2 -> busy high T0+1..T0+5, low at T0+6; at T0+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu A=7 B=2 -> LO=3, HI=1.
- mthi A=0x12345678 then div A=5 B=0 -> HI=0x12345678 unchanged after 10 busy cycles; mflo gives md_out = the previous LO.
- D_md_use=1 during the start cycle of mult and every busy cycle -> md_stall=1 on exactly those 6 cycles. A mflo in D with busy=0 and no launch -> md_stall=0.
- Assert reset at T0+3 of a div -> busy=0, HI=LO=0 immediately; no later commit occurs.
